// File: rtl/etapa_fetch.sv
// etapa_fetch -- instruction-fetch stage in front of the 128-byte instruction ROM.
//
// The stage owns the program counter and drives it straight onto the ROM
// address. Because the ROM is combinational, the four bytes for the current
// PC arrive in the same cycle. They are captured into a 32-bit instruction
// register and offered to the decoder over a valid/ready handshake.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset (dominates everything)
//   Direccion    ROM address (the PC register)
//   B1..B4       ROM bytes at Direccion..Direccion+3 (B1 most significant)
//   SaltoEn      branch/jump redirect request from execute
//   DirSalto     branch target address (used unaligned as given)
//   Listo_dec    decoder ready
//   Instruccion  instruction register {B1,B2,B3,B4}
//   InstrValida  Instruccion holds an instruction not yet accepted
//   Detenido     stage is halted
//   CuentaInstr  saturating count of instructions accepted by the decoder
module etapa_fetch #(
  parameter int          ADDR_W   = 7,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4,
  parameter logic [7:0]  HALT_OP  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] Direccion,
  input  logic [7:0]        B1,
  input  logic [7:0]        B2,
  input  logic [7:0]        B3,
  input  logic [7:0]        B4,
  input  logic              SaltoEn,
  input  logic [ADDR_W-1:0] DirSalto,
  input  logic              Listo_dec,
  output logic [31:0]       Instruccion,
  output logic              InstrValida,
  output logic              Detenido,
  output logic [15:0]       CuentaInstr
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_p0;
  logic [31:0]       instr_p1;
  logic              vld_p1;
  logic [15:0]       cnt_p1;

  logic acc;
  logic load;
  logic redirect;
  logic is_halt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    // Wraps naturally at 2^ADDR_W.
    return pc + ADDR_W'(PC_STEP);
  endfunction

  assign acc      = vld_p1 & Listo_dec;
  assign redirect = (state == FETCH) & SaltoEn;
  // A new word may enter only when the register is empty or being drained.
  assign load     = (state == FETCH) & ~SaltoEn & (~vld_p1 | Listo_dec);
  assign is_halt  = (B1 == HALT_OP);

  always_comb begin
    state_nxt = state;
    if (load && is_halt) state_nxt = HALT;
  end

  // Stage p0 -> p1: PC / ROM address to instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc_p0    <= ADDR_W'(RESET_PC);
      instr_p1 <= 32'd0;
      vld_p1   <= 1'b0;
      cnt_p1   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (acc) cnt_p1 <= sat_inc(cnt_p1);
      if (redirect) begin
        // Flush: the held word is dropped, the target is fetched next cycle.
        pc_p0  <= DirSalto;
        vld_p1 <= 1'b0;
      end else if (load) begin
        instr_p1 <= {B1, B2, B3, B4};
        vld_p1   <= 1'b1;
        // The halt word itself is delivered, but the PC stays on it.
        if (!is_halt) pc_p0 <= pc_next(pc_p0);
      end else if (acc) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign Direccion   = pc_p0;
  assign Instruccion = instr_p1;
  assign InstrValida = vld_p1;
  assign Detenido    = (state == HALT);
  assign CuentaInstr = cnt_p1;

endmodule

// File: tb/tb_etapa_fetch.sv
module tb_etapa_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Direccion;
  logic [7:0]  B1, B2, B3, B4;
  logic        SaltoEn;
  logic [6:0]  DirSalto;
  logic        Listo_dec;
  logic [31:0] Instruccion;
  logic        InstrValida;
  logic        Detenido;
  logic [15:0] CuentaInstr;

  logic [7:0]  rom [128];
  logic [6:0]  a1, a2, a3;

  logic [31:0] sbq [$];
  logic        chk_en;
  int          ntests = 0;
  int          nfail  = 0;

  always #5 clk = ~clk;

  assign a1 = Direccion + 7'd1;
  assign a2 = Direccion + 7'd2;
  assign a3 = Direccion + 7'd3;
  assign B1 = rom[Direccion];
  assign B2 = rom[a1];
  assign B3 = rom[a2];
  assign B4 = rom[a3];

  etapa_fetch dut (
    .clk(clk),
    .reset(reset),
    .Direccion(Direccion),
    .B1(B1),
    .B2(B2),
    .B3(B3),
    .B4(B4),
    .SaltoEn(SaltoEn),
    .DirSalto(DirSalto),
    .Listo_dec(Listo_dec),
    .Instruccion(Instruccion),
    .InstrValida(InstrValida),
    .Detenido(Detenido),
    .CuentaInstr(CuentaInstr)
  );

  // Scoreboard monitor: every handshake must deliver the next expected word.
  always @(negedge clk) begin
    if (chk_en && !reset && InstrValida && Listo_dec) begin
      ntests++;
      if (sbq.size() == 0) begin
        nfail++;
        $display("FAIL sb_unexpected: got %h, expected no accepted word", Instruccion);
      end else begin
        logic [31:0] e;
        e = sbq.pop_front();
        if (Instruccion !== e) begin
          nfail++;
          $display("FAIL sb_word: got %h, expected %h", Instruccion, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_word(input int addr, input logic [31:0] w);
    rom[addr]   = w[31:24];
    rom[addr+1] = w[23:16];
    rom[addr+2] = w[15:8];
    rom[addr+3] = w[7:0];
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    SaltoEn   = 1'b0;
    DirSalto  = 7'd0;
    Listo_dec = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_dir"},   32'(Direccion),   32'd0);
    chk({tag, "_vld"},   32'(InstrValida), 32'd0);
    chk({tag, "_instr"}, Instruccion,      32'd0);
    chk({tag, "_det"},   32'(Detenido),    32'd0);
    chk({tag, "_cnt"},   32'(CuentaInstr), 32'd0);
  endtask

  initial begin
    chk_en = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    set_word(0, 32'h01020304);
    set_word(4, 32'h05060708);
    set_word(8, 32'h090A0B0C);
    set_word(40, 32'hA1A2A3A4);
    set_word(44, 32'hB1B2B3B4);
    rom[126] = 8'hC1;
    rom[127] = 8'hC2;

    // Sequential fetch with the decoder always ready
    do_reset();
    chk_reset_state("rst");
    sbq.push_back(32'h01020304);
    sbq.push_back(32'h05060708);
    sbq.push_back(32'h090A0B0C);
    Listo_dec = 1'b1;
    step();
    chk("seq_e1_instr", Instruccion, 32'h01020304);
    chk("seq_e1_vld", 32'(InstrValida), 32'd1);
    chk("seq_e1_dir", 32'(Direccion), 32'd4);
    step();
    chk("seq_e2_instr", Instruccion, 32'h05060708);
    chk("seq_e2_dir", 32'(Direccion), 32'd8);
    step();
    chk("seq_e3_instr", Instruccion, 32'h090A0B0C);
    chk("seq_e3_dir", 32'(Direccion), 32'd12);
    step();
    Listo_dec = 1'b0;
    chk("seq_e4_cnt", 32'(CuentaInstr), 32'd3);

    // Stall for three cycles, then release
    do_reset();
    sbq.push_back(32'h01020304);
    sbq.push_back(32'h05060708);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", Instruccion, 32'h01020304);
      chk("stall_dir", 32'(Direccion), 32'd4);
      chk("stall_cnt", 32'(CuentaInstr), 32'd0);
    end
    Listo_dec = 1'b1;
    step();
    chk("rel_instr", Instruccion, 32'h05060708);
    chk("rel_dir", 32'(Direccion), 32'd8);
    chk("rel_cnt", 32'(CuentaInstr), 32'd1);
    step();
    Listo_dec = 1'b0;
    chk("rel2_instr", Instruccion, 32'h090A0B0C);
    chk("rel2_cnt", 32'(CuentaInstr), 32'd2);

    // Branch while stalled flushes the held word; then branch with accept
    do_reset();
    step();
    chk("br_pre_vld", 32'(InstrValida), 32'd1);
    SaltoEn  = 1'b1;
    DirSalto = 7'd40;
    step();
    SaltoEn = 1'b0;
    chk("br_flush_vld", 32'(InstrValida), 32'd0);
    chk("br_flush_dir", 32'(Direccion), 32'd40);
    chk("br_flush_cnt", 32'(CuentaInstr), 32'd0);
    step();
    chk("br_tgt_instr", Instruccion, 32'hA1A2A3A4);
    chk("br_tgt_vld", 32'(InstrValida), 32'd1);
    chk("br_tgt_dir", 32'(Direccion), 32'd44);
    sbq.push_back(32'hA1A2A3A4);
    Listo_dec = 1'b1;
    step();
    chk("br_acc_cnt", 32'(CuentaInstr), 32'd1);
    chk("br_acc_instr", Instruccion, 32'hB1B2B3B4);
    sbq.push_back(32'hB1B2B3B4);
    SaltoEn  = 1'b1;
    DirSalto = 7'd126;
    step();
    SaltoEn   = 1'b0;
    Listo_dec = 1'b0;
    chk("br2_cnt", 32'(CuentaInstr), 32'd2);
    chk("br2_vld", 32'(InstrValida), 32'd0);
    chk("br2_dir", 32'(Direccion), 32'd126);
    step();
    chk("unal_instr", Instruccion, 32'hC1C20102);
    chk("unal_dir", 32'(Direccion), 32'd2);
    sbq.push_back(32'hC1C20102);
    Listo_dec = 1'b1;
    step();
    Listo_dec = 1'b0;
    chk("unal_cnt", 32'(CuentaInstr), 32'd3);

    // PC wrap from 124 to 0
    set_word(124, 32'hD1D2D3D4);
    do_reset();
    SaltoEn  = 1'b1;
    DirSalto = 7'd124;
    step();
    SaltoEn = 1'b0;
    chk("wrap_dir124", 32'(Direccion), 32'd124);
    step();
    chk("wrap_instr", Instruccion, 32'hD1D2D3D4);
    chk("wrap_dir0", 32'(Direccion), 32'd0);
    sbq.push_back(32'hD1D2D3D4);
    sbq.push_back(32'h01020304);
    Listo_dec = 1'b1;
    step();
    chk("wrap_next_instr", Instruccion, 32'h01020304);
    chk("wrap_next_dir", 32'(Direccion), 32'd4);
    step();
    Listo_dec = 1'b0;
    chk("wrap_cnt", 32'(CuentaInstr), 32'd2);

    // Halt opcode at address 8
    set_word(8, 32'hFF112233);
    do_reset();
    sbq.push_back(32'h01020304);
    sbq.push_back(32'h05060708);
    sbq.push_back(32'hFF112233);
    Listo_dec = 1'b1;
    step();
    step();
    step();
    Listo_dec = 1'b0;
    chk("halt_instr", Instruccion, 32'hFF112233);
    chk("halt_vld", 32'(InstrValida), 32'd1);
    chk("halt_det", 32'(Detenido), 32'd1);
    chk("halt_dir", 32'(Direccion), 32'd8);
    chk("halt_cnt", 32'(CuentaInstr), 32'd2);
    SaltoEn  = 1'b1;
    DirSalto = 7'd40;
    step();
    SaltoEn = 1'b0;
    chk("halt_br_dir", 32'(Direccion), 32'd8);
    chk("halt_br_vld", 32'(InstrValida), 32'd1);
    chk("halt_br_det", 32'(Detenido), 32'd1);
    Listo_dec = 1'b1;
    step();
    chk("halt_drain_cnt", 32'(CuentaInstr), 32'd3);
    chk("halt_drain_vld", 32'(InstrValida), 32'd0);
    step();
    chk("halt_idle_cnt", 32'(CuentaInstr), 32'd3);
    chk("halt_idle_dir", 32'(Direccion), 32'd8);
    chk("halt_idle_det", 32'(Detenido), 32'd1);
    do_reset();
    chk_reset_state("halt_rst");

    // Reset while stalled with a valid instruction
    set_word(8, 32'h090A0B0C);
    sbq.push_back(32'h01020304);
    Listo_dec = 1'b1;
    step();
    step();
    Listo_dec = 1'b0;
    step();
    chk("rs_pre_cnt", 32'(CuentaInstr), 32'd1);
    chk("rs_pre_vld", 32'(InstrValida), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_state("rs");
    reset = 1'b0;

    // Counter saturation (contents not checked during the bulk run)
    chk_en = 1'b0;
    Listo_dec = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    chk("sat_fffe", 32'(CuentaInstr), 32'h0000FFFE);
    step();
    chk("sat_ffff", 32'(CuentaInstr), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) step();
    chk("sat_hold", 32'(CuentaInstr), 32'h0000FFFF);
    Listo_dec = 1'b0;
    step();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
